sev_segs_bcd_driver: RTL and testbench

//   Multi-digit seven-segment driver for the DE10 HEX displays; successor to the

---
 rtl/sev_segs_bcd_driver.sv | 193 +++++++++++++++++++
 tb/tb_sev_segs_bcd_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sev_segs_bcd_driver.sv
// Multi-digit seven-segment driver: captures a binary value, converts it to BCD
// (shift-add-3, one bit per clock) or splits it into hex nibbles, and drives HEX digits.
module sev_segs_bcd_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_WIDTH = 20,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   value,
  input  logic                    mode_hex,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] sev_segs
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int SEG_W   = 7 * NUM_DIGITS;
  localparam int PAD_W   = DATA_WIDTH + BCD_W;
  localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      bit_cnt;
  logic                  mode_r;
  logic                  carry;
  logic                  shown;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0]      bcd_reg;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      disp_nibs;
  logic [PAD_W-1:0]      padded;
  logic [BCD_W-1:0]      upd_nibs;
  logic                  upd_ovf;
  logic [BCD_W-1:0]      src_nibs;
  logic                  src_ovf;
  logic                  src_vis;
  logic [SEG_W-1:0]      seg_nxt;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_on;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Builds the visible pattern: all-blank when hidden, dashes on overflow,
  // otherwise decoded digits with optional leading-zero suppression.
  function automatic logic [SEG_W-1:0] render(input logic [BCD_W-1:0] nibs,
                                              input logic vis, input logic ovf,
                                              input logic blz, input logic blank_all);
    logic [SEG_W-1:0] r;
    logic             lead;
    r    = '1;
    lead = 1'b1;
    if (vis && !blank_all) begin
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
        if (nibs[4*k +: 4] != 4'h0) lead = 1'b0;
        if (ovf)                          r[7*k +: 7] = 7'h3F;
        else if (blz && lead && (k != 0)) r[7*k +: 7] = 7'h7F;
        else                              r[7*k +: 7] = decode(nibs[4*k +: 4]);
      end
    end
    return r;
  endfunction

  assign busy    = (state != S_IDLE);
  assign bcd_adj = add3_all(bcd_reg);
  assign padded  = {{BCD_W{1'b0}}, shift_reg};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (load) state_nxt = mode_hex ? S_UPDATE : S_CONVERT;
      S_CONVERT: if (bit_cnt == CNT_W'(1)) state_nxt = S_UPDATE;
      S_UPDATE:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // In the update cycle the output register is fed from the fresh result so
  // sev_segs and done change on the same edge.
  always_comb begin
    upd_nibs = mode_r ? padded[BCD_W-1:0] : bcd_reg;
    upd_ovf  = mode_r ? (|padded[PAD_W-1:BCD_W]) : carry;
    src_nibs = disp_nibs;
    src_ovf  = overflow;
    src_vis  = shown;
    if (state == S_UPDATE) begin
      src_nibs = upd_nibs;
      src_ovf  = upd_ovf;
      src_vis  = 1'b1;
    end
    seg_nxt = render(src_nibs, src_vis, src_ovf, blank_lz, blink_en && !blink_on);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      mode_r   <= 1'b0;
      carry    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      shown    <= 1'b0;
      sev_segs <= '1;
    end else begin
      state    <= state_nxt;
      done     <= (state == S_UPDATE);
      sev_segs <= seg_nxt;
      case (state)
        S_IDLE: if (load) begin
          mode_r  <= mode_hex;
          carry   <= 1'b0;
          bit_cnt <= CNT_W'(DATA_WIDTH);
        end
        S_CONVERT: begin
          carry   <= carry | bcd_adj[BCD_W-1];
          bit_cnt <= bit_cnt - CNT_W'(1);
        end
        S_UPDATE: begin
          overflow <= upd_ovf;
          shown    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (load) begin
        shift_reg <= value;
        bcd_reg   <= '0;
      end
      S_CONVERT: {bcd_reg, shift_reg} <= {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
      S_UPDATE:  disp_nibs <= upd_nibs;
      default: ;
    endcase
  end

  // Free-running blink timebase; phase starts visible out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_sev_segs_bcd_driver.sv
// Directed bench for sev_segs_bcd_driver (6 digits, 20-bit value, fast blink).
module tb_sev_segs_bcd_driver;

  localparam logic [41:0] ALL7F = {6{7'h7F}};
  localparam logic [41:0] ALL3F = {6{7'h3F}};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [19:0] value = '0;
  logic        mode_hex = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic        busy, done, overflow;
  logic [41:0] sev_segs;

  int tests = 0;
  int fails = 0;
  int cyc;
  logic [41:0] vis7;
  logic [41:0] exp_segs;
  logic        seen;

  sev_segs_bcd_driver #(.NUM_DIGITS(6), .DATA_WIDTH(20), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .mode_hex(mode_hex),
    .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .done(done),
    .overflow(overflow), .sev_segs(sev_segs)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [41:0] segs(input logic [6:0] d5, input logic [6:0] d4,
                                       input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load edge counts as edge 1; returns at the negedge of the done cycle.
  task automatic load_val(input string tag, input logic [19:0] v, input logic hex,
                          input int exp_lat, input int inj_at);
    int got;
    @(negedge clk);
    value = v; mode_hex = hex; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    got = 0;
    for (int n = 1; n <= 60 && got == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (n == inj_at + 1 && inj_at > 0) load = 1'b0;
      if (done) got = n;
      else if (n == inj_at) begin
        value = 20'd999; load = 1'b1;
      end
    end
    load = 1'b0;
    check({tag, " latency"}, 64'(got), 64'(exp_lat));
  endtask

  initial begin
    #12;
    check("reset segs", 64'(sev_segs), 64'(ALL7F));
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    load_val("dec123456", 20'd123456, 1'b0, 22, 0);
    check("dec123456 segs", 64'(sev_segs),
          64'(segs(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02)));
    check("dec123456 ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    check("done pulse width", 64'(done), 64'd0);

    blank_lz = 1'b1;
    load_val("hexABCDE", 20'hABCDE, 1'b1, 2, 0);
    check("hexABCDE segs", 64'(sev_segs),
          64'(segs(7'h7F, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06)));

    load_val("dec42", 20'd42, 1'b0, 22, 0);
    check("dec42 segs", 64'(sev_segs),
          64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24)));
    blank_lz = 1'b0;
    @(negedge clk);
    check("dec42 no blank", 64'(sev_segs),
          64'(segs(7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24)));
    blank_lz = 1'b1;
    @(negedge clk);
    check("dec42 reblank", 64'(sev_segs),
          64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24)));

    load_val("dec0", 20'd0, 1'b0, 22, 0);
    check("dec0 segs", 64'(sev_segs),
          64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)));

    load_val("dec1M", 20'd1_000_000, 1'b0, 22, 0);
    check("dec1M segs", 64'(sev_segs), 64'(ALL3F));
    check("dec1M ovf", 64'(overflow), 64'd1);

    load_val("dec7", 20'd7, 1'b0, 22, 0);
    check("dec7 segs", 64'(sev_segs),
          64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78)));
    check("dec7 ovf", 64'(overflow), 64'd0);

    load_val("dec5 inj999", 20'd5, 1'b0, 22, 5);
    check("dec5 segs", 64'(sev_segs),
          64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12)));

    // abort a conversion with reset
    @(negedge clk);
    value = 20'd123; mode_hex = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort segs", 64'(sev_segs), 64'(ALL7F));
    check("abort busy", 64'(busy), 64'd0);
    check("abort ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort no done", 64'(seen), 64'd0);
    check("abort idle", 64'(busy), 64'd0);

    // blink: after edge k the output is hidden when ((k-1)/4) is odd
    reset = 1'b1; blink_en = 1'b1; blank_lz = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    value = 20'h7; mode_hex = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vis7 = segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78);
    while (cyc < 10) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp_segs = ((((cyc - 1) / 4) % 2) == 1) ? ALL7F : vis7;
      check($sformatf("blink cyc%0d", cyc), 64'(sev_segs), 64'(exp_segs));
      @(negedge clk);
    end
    for (int i = 0; i < 16 && (cyc % 8) != 5; i++) @(negedge clk);
    check("blink hidden", 64'(sev_segs), 64'(ALL7F));
    blink_en = 1'b0;
    @(negedge clk);
    check("blink off visible", 64'(sev_segs), 64'(vis7));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
